// File: rtl/vga_timing_decoder.sv
// Sync-only VGA receiver: recovers pixel coordinates from the hsync/vsync pair, qualifies them
// with a lock state machine and flags line and frame timing errors.
module vga_timing_decoder #(
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned LOCK_FRAMES  = 2
) (
  input  logic        clk_div,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic        active,
  output logic        frame_start,
  output logic        locked,
  output logic        h_error,
  output logic        v_error,
  output logic [7:0]  error_count
);
  localparam logic [15:0] HVis       = 16'(H_VISIBLE);
  localparam logic [15:0] HSync      = 16'(H_SYNC_START);
  localparam logic [15:0] HPre       = 16'(H_SYNC_START - 1);
  localparam logic [15:0] HLast      = 16'(H_TOTAL - 1);
  localparam logic [15:0] VVis       = 16'(V_VISIBLE);
  localparam logic [15:0] VSync      = 16'(V_SYNC_START);
  localparam logic [15:0] VLast      = 16'(V_TOTAL - 1);
  localparam logic [15:0] WdLast     = 16'(2 * H_TOTAL - 1);
  localparam logic [15:0] WdLimit    = 16'(2 * H_TOTAL);
  localparam logic [7:0]  LockFrames = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked} state_e;

  state_e      r_state, w_state_d;
  logic        r_hs_q, r_vs_q, r_h_synced, r_v_synced;
  logic [15:0] r_x, r_y, r_wd;
  logic [7:0]  r_good, r_err_cnt;
  logic        r_active, r_frame_start, r_h_error, r_v_error;

  logic        w_hs_fall, w_vs_fall, w_x_wrap, w_wd_expire;
  logic        w_h_err, w_v_err, w_err, w_h_synced_d, w_v_synced_d;
  logic [15:0] w_x_d, w_y_nat, w_y_d, w_wd_d;
  logic [7:0]  w_good_d, w_cnt_d;

  always_comb begin
    w_hs_fall = r_hs_q & ~hsync;
    w_vs_fall = r_vs_q & ~vsync;
    w_x_wrap  = ~w_hs_fall & (r_x == HLast);
    w_x_d     = w_hs_fall ? HSync : (w_x_wrap ? 16'd0 : r_x + 16'd1);
    w_y_nat   = r_y;
    if (w_x_wrap) w_y_nat = (r_y == VLast) ? 16'd0 : r_y + 16'd1;
    // vsync alignment overrides the line increment; the check uses the value it replaced
    w_y_d       = w_vs_fall ? VSync : w_y_nat;
    w_wd_expire = ~w_hs_fall & (r_wd == WdLast);
    w_wd_d      = w_hs_fall ? 16'd0 : ((r_wd == WdLimit) ? r_wd : r_wd + 16'd1);
    w_h_err     = (w_hs_fall & r_h_synced & (r_x != HPre)) | w_wd_expire;
    w_v_err     = w_vs_fall & r_v_synced & (w_y_nat != VSync);
    w_err       = w_h_err | w_v_err;
    // first edge after reset or loss of sync realigns silently
    w_h_synced_d = ~w_wd_expire & (r_h_synced | w_hs_fall);
    w_v_synced_d = ~w_wd_expire & (r_v_synced | w_vs_fall);
  end

  always_comb begin
    w_state_d = r_state;
    w_good_d  = r_good;
    if (w_wd_expire) begin
      w_state_d = StUnlocked;
      w_good_d  = 8'd0;
    end else begin
      unique case (r_state)
        StUnlocked: begin
          if (w_vs_fall) begin
            w_state_d = StAcquire;
            w_good_d  = 8'd0;
          end
        end
        StAcquire: begin
          if (w_err) begin
            w_good_d = 8'd0;
          end else if (w_vs_fall) begin
            if (r_good + 8'd1 >= LockFrames) begin
              w_state_d = StLocked;
              w_good_d  = 8'd0;
            end else begin
              w_good_d = r_good + 8'd1;
            end
          end
        end
        StLocked: begin
          if (w_err) begin
            w_state_d = StAcquire;
            w_good_d  = 8'd0;
          end
        end
        default: begin
          w_state_d = StUnlocked;
          w_good_d  = 8'd0;
        end
      endcase
    end
    w_cnt_d = r_err_cnt;
    if ((r_state == StLocked) && w_err && (r_err_cnt != 8'hFF)) w_cnt_d = r_err_cnt + 8'd1;
  end

  always_ff @(posedge clk_div) begin
    if (reset) begin
      r_state       <= StUnlocked;
      r_hs_q        <= 1'b1;
      r_vs_q        <= 1'b1;
      r_h_synced    <= 1'b0;
      r_v_synced    <= 1'b0;
      r_x           <= 16'd0;
      r_y           <= 16'd0;
      r_wd          <= 16'd0;
      r_good        <= 8'd0;
      r_err_cnt     <= 8'd0;
      r_active      <= 1'b0;
      r_frame_start <= 1'b0;
      r_h_error     <= 1'b0;
      r_v_error     <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_hs_q        <= hsync;
      r_vs_q        <= vsync;
      r_h_synced    <= w_h_synced_d;
      r_v_synced    <= w_v_synced_d;
      r_x           <= w_x_d;
      r_y           <= w_y_d;
      r_wd          <= w_wd_d;
      r_good        <= w_good_d;
      r_err_cnt     <= w_cnt_d;
      r_active      <= (w_state_d == StLocked) & (w_x_d < HVis) & (w_y_d < VVis);
      r_frame_start <= (w_state_d == StLocked) & (w_x_d == 16'd0) & (w_y_d == 16'd0);
      r_h_error     <= w_h_err;
      r_v_error     <= w_v_err;
    end
  end

  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign active      = r_active;
  assign frame_start = r_frame_start;
  assign locked      = (r_state == StLocked);
  assign h_error     = r_h_error;
  assign v_error     = r_v_error;
  assign error_count = r_err_cnt;

endmodule
